arp_tx: RTL and testbench

ARP transmit stage sitting directly downstream of the ARP receive stage. It consumes the captured sender MAC/IP and the reply trigger from the receiver, plus a local request trigger. It serialises a 28-byte ARP payload, either a reply (OPER=2) or a request (OPER=1), as a byte stream into the MAC transmit layer.

---
 rtl/arp_pkg.sv | 28 ++
 rtl/arp_tx_if.sv | 25 ++
 rtl/arp_tx_byte_sel.sv | 31 +++
 rtl/arp_tx.sv | 140 ++++++++++++++
 tb/tb_arp_tx.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arp_pkg.sv
// ARP transmit shared definitions: field constants, lengths, FSM state
// and the per-frame snapshot bundle.
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'd6;
  localparam logic [7:0]  ARP_PLEN       = 8'd4;
  localparam logic [15:0] ARP_OP_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OP_REPLY   = 16'd2;
  localparam int          ARP_LEN        = 28;
  localparam int          ARP_PAD_LEN    = 46;
  localparam logic [47:0] MAC_BROADCAST  = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } arp_state_e;

  typedef struct packed {
    logic [15:0] oper;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_fld_t;

endpackage

// File: rtl/arp_tx_if.sv
// Byte stream from the ARP transmitter into the MAC transmit layer.
// master = ARP side, slave = MAC side.
interface arp_tx_if;
  logic [47:0] o_dst_mac;
  logic [7:0]  o_mac_data;
  logic        o_mac_last;
  logic        o_mac_valid;
  logic        i_mac_ready;

  modport master (
    output o_dst_mac,
    output o_mac_data,
    output o_mac_last,
    output o_mac_valid,
    input  i_mac_ready
  );

  modport slave (
    input  o_dst_mac,
    input  o_mac_data,
    input  o_mac_last,
    input  o_mac_valid,
    output i_mac_ready
  );
endinterface

// File: rtl/arp_tx_byte_sel.sv
// Selects the ARP payload byte for a given index from the frame snapshot.
// Indices past the 28-byte payload yield 0x00, which doubles as padding.
module arp_tx_byte_sel
  import arp_pkg::*;
#(
  parameter logic [47:0] P_SOURCE_MAC = 48'h0
) (
  input  arp_fld_t   i_fld,
  input  logic [5:0] i_idx,
  output logic [7:0] o_data
);

  logic [223:0] pl;
  logic [7:0]   b [32];

  assign pl = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN,
               i_fld.oper, P_SOURCE_MAC, i_fld.spa,
               i_fld.tha, i_fld.tpa};

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      b[i] = 8'h00;
    end
    for (int i = 0; i < ARP_LEN; i++) begin
      b[i] = pl[223-8*i -: 8];
    end
  end

  assign o_data = i_idx[5] ? 8'h00 : b[i_idx[4:0]];

endmodule

// File: rtl/arp_tx.sv
// ARP transmit stage: captures addresses, arbitrates reply/request and
// serialises the ARP payload. Define ARP_TX_PAD_EN to pad to 46 bytes.
module arp_tx
  import arp_pkg::*;
#(
  parameter logic [31:0] P_TARGET_IP  = {8'd192, 8'd168, 8'd1, 8'd1},
  parameter logic [47:0] P_SOURCE_MAC = 48'h0,
  parameter logic [31:0] P_SOURCE_IP  = {8'd192, 8'd168, 8'd1, 8'd2}
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_source_ip,
  input  logic        i_s_ip_valid,
  input  logic [31:0] i_target_ip_req,
  input  logic        i_arp_active,
  input  logic [47:0] i_target_mac,
  input  logic [31:0] i_target_ip,
  input  logic        i_target_valid,
  input  logic        i_trig_reply,
  arp_tx_if.master    mac
);

`ifdef ARP_TX_PAD_EN
  localparam logic [5:0] LAST_IDX = 6'(ARP_PAD_LEN - 1);
`else
  localparam logic [5:0] LAST_IDX = 6'(ARP_LEN - 1);
`endif

  arp_state_e  state_q, state_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [47:0] tgt_mac_q, tgt_mac_d;
  logic [31:0] tgt_ip_q, tgt_ip_d;
  logic [31:0] req_ip_q, req_ip_d;
  logic        rep_pend_q, rep_pend_d;
  logic        req_pend_q, req_pend_d;
  logic [5:0]  idx_q, idx_d;
  arp_fld_t    fld_q, fld_d;
  logic [47:0] dst_q, dst_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic        grant_rep, grant_req;
  logic [7:0]  sel_data;

  always_comb begin
    state_d   = state_q;
    src_ip_d  = i_s_ip_valid ? i_source_ip : src_ip_q;
    tgt_mac_d = i_target_valid ? i_target_mac : tgt_mac_q;
    tgt_ip_d  = i_target_valid ? i_target_ip : tgt_ip_q;
    req_ip_d  = i_arp_active ? i_target_ip_req : req_ip_q;
    idx_d     = idx_q;
    fld_d     = fld_q;
    dst_d     = dst_q;
    valid_d   = 1'b0;
    grant_rep = 1'b0;
    grant_req = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((rep_pend_q || req_pend_q) && mac.i_mac_ready) begin
          grant_rep = rep_pend_q;
          grant_req = !rep_pend_q;
          if (rep_pend_q) begin
            fld_d = '{ARP_OP_REPLY, src_ip_q, tgt_mac_q, tgt_ip_q};
            dst_d = tgt_mac_q;
          end else begin
            fld_d = '{ARP_OP_REQUEST, src_ip_q, 48'h0, req_ip_q};
            dst_d = MAC_BROADCAST;
          end
          idx_d   = 6'd0;
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_GAP;
        end else begin
          idx_d   = idx_q + 6'd1;
          valid_d = 1'b1;
        end
      end
      S_GAP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // a pulse landing on an already-set flag merges into that frame
    rep_pend_d = rep_pend_q ? !grant_rep : i_trig_reply;
    req_pend_d = req_pend_q ? !grant_req : i_arp_active;
  end

  arp_tx_byte_sel #(
    .P_SOURCE_MAC(P_SOURCE_MAC)
  ) u_byte_sel (
    .i_fld (fld_d),
    .i_idx (idx_d),
    .o_data(sel_data)
  );

  always_comb begin
    data_d = valid_d ? sel_data : 8'h00;
    last_d = valid_d && (idx_d == LAST_IDX);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      src_ip_q   <= P_SOURCE_IP;
      tgt_mac_q  <= '0;
      tgt_ip_q   <= '0;
      req_ip_q   <= P_TARGET_IP;
      rep_pend_q <= 1'b0;
      req_pend_q <= 1'b0;
      idx_q      <= '0;
      fld_q      <= '0;
      dst_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_ip_q   <= src_ip_d;
      tgt_mac_q  <= tgt_mac_d;
      tgt_ip_q   <= tgt_ip_d;
      req_ip_q   <= req_ip_d;
      rep_pend_q <= rep_pend_d;
      req_pend_q <= req_pend_d;
      idx_q      <= idx_d;
      fld_q      <= fld_d;
      dst_q      <= dst_d;
      data_q     <= data_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

  assign mac.o_dst_mac   = dst_q;
  assign mac.o_mac_data  = data_q;
  assign mac.o_mac_last  = last_q;
  assign mac.o_mac_valid = valid_q;

endmodule

// File: tb/tb_arp_tx.sv
// Directed testbench for arp_tx: reply/request framing, arbitration,
// ready stall, mid-frame capture, mid-frame reset, optional padding.
module tb_arp_tx;

`ifdef ARP_TX_PAD_EN
  localparam int EXP_N = 46;
`else
  localparam int EXP_N = 28;
`endif

  localparam logic [47:0] MAC1 = 48'h1122_3344_5566;
  localparam logic [47:0] MAC2 = 48'hAABB_CCDD_EEFF;
  localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;

  localparam logic [223:0] R1 =
    224'h0001_0800_0604_0002_02AABBCCDDEE_C0A80102_112233445566_C0A80101;
  localparam logic [223:0] Q1 =
    224'h0001_0800_0604_0001_02AABBCCDDEE_C0A80102_000000000000_C0A80109;
  localparam logic [223:0] Q3 =
    224'h0001_0800_0604_0001_02AABBCCDDEE_C0A80102_000000000000_C0A80107;
  localparam logic [223:0] R5 =
    224'h0001_0800_0604_0002_02AABBCCDDEE_C0A80102_AABBCCDDEEFF_C0A80163;
  localparam logic [223:0] Q6 =
    224'h0001_0800_0604_0001_02AABBCCDDEE_0A000005_000000000000_C0A80109;
  localparam logic [223:0] R7 =
    224'h0001_0800_0604_0002_02AABBCCDDEE_C0A80102_000000000000_00000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] source_ip;
  logic        s_ip_valid;
  logic [31:0] target_ip_req;
  logic        arp_active;
  logic [47:0] target_mac;
  logic [31:0] target_ip;
  logic        target_valid;
  logic        trig_reply;

  logic [47:0] inj_mac;
  logic [31:0] inj_ip;

  int n_asrt = 0;
  int n_fail = 0;

  arp_tx_if mif ();

  arp_tx #(
    .P_SOURCE_MAC(48'h02AA_BBCC_DDEE)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_source_ip    (source_ip),
    .i_s_ip_valid   (s_ip_valid),
    .i_target_ip_req(target_ip_req),
    .i_arp_active   (arp_active),
    .i_target_mac   (target_mac),
    .i_target_ip    (target_ip),
    .i_target_valid (target_valid),
    .i_trig_reply   (trig_reply),
    .mac            (mif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [223:0] obs,
                     input logic [223:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input int budget, output bit ok,
                            output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      if (mif.o_mac_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      waited++;
    end
  endtask

  task automatic collect(input int abort_at, input int inj_at,
                         output logic [223:0] v, output int n,
                         output int lastpos, output int lastcnt,
                         output logic [7:0] padnz,
                         output logic [47:0] dst, output bit dst_ok,
                         output bit aborted);
    v = '0;
    n = 0;
    lastpos = -1;
    lastcnt = 0;
    padnz = 8'h00;
    dst = mif.o_dst_mac;
    dst_ok = 1'b1;
    aborted = 1'b0;
    while (mif.o_mac_valid === 1'b1 && n < 64) begin
      if (n == abort_at) begin
        rst = 1'b1;
        #1;
        chk("reset_mid_outputs",
            {mif.o_mac_valid, mif.o_mac_last, mif.o_mac_data,
             mif.o_dst_mac}, '0);
        tick();
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (n < 28) v[223-8*n -: 8] = mif.o_mac_data;
      else padnz = padnz | mif.o_mac_data;
      if (mif.o_mac_last === 1'b1) begin
        lastpos = n;
        lastcnt++;
      end
      if (mif.o_dst_mac !== dst) dst_ok = 1'b0;
      if (n == inj_at) begin
        target_mac = inj_mac;
        target_ip = inj_ip;
        target_valid = 1'b1;
        trig_reply = 1'b1;
      end
      if (n == inj_at + 1) begin
        target_valid = 1'b0;
        trig_reply = 1'b0;
      end
      n++;
      tick();
    end
    target_valid = 1'b0;
    trig_reply = 1'b0;
  endtask

  task automatic frame_check(input string tag, input logic [223:0] ev,
                             input logic [47:0] edst, input int inj_at);
    logic [223:0] v;
    int n, lp, lc;
    logic [7:0] pz;
    logic [47:0] d;
    bit dok, ab;
    collect(-1, inj_at, v, n, lp, lc, pz, d, dok, ab);
    chk({tag, "_bytes"}, v, ev);
    chk({tag, "_len"}, n, EXP_N);
    chk({tag, "_lastpos"}, lp, EXP_N - 1);
    chk({tag, "_lastcnt"}, lc, 1);
    chk({tag, "_pad"}, pz, 8'h00);
    chk({tag, "_dst"}, d, edst);
    chk({tag, "_dst_stable"}, dok, 1'b1);
  endtask

  task automatic pulse_reply();
    trig_reply = 1'b1;
    tick();
    trig_reply = 1'b0;
  endtask

  task automatic pulse_req(input logic [31:0] ip);
    target_ip_req = ip;
    arp_active = 1'b1;
    tick();
    arp_active = 1'b0;
  endtask

  initial begin
    bit ok, seen, ab;
    int w, n, lp, lc;
    logic [223:0] v;
    logic [7:0] pz;
    logic [47:0] d;
    bit dok;

    rst = 1'b1;
    source_ip = '0;
    s_ip_valid = 1'b0;
    target_ip_req = '0;
    arp_active = 1'b0;
    target_mac = '0;
    target_ip = '0;
    target_valid = 1'b0;
    trig_reply = 1'b0;
    inj_mac = MAC2;
    inj_ip = 32'hC0A8_0163;
    mif.i_mac_ready = 1'b1;
    repeat (3) tick();
    chk("reset_outputs",
        {mif.o_mac_valid, mif.o_mac_last, mif.o_mac_data,
         mif.o_dst_mac}, '0);
    rst = 1'b0;
    tick();
    wait_frame(10, ok, w);
    chk("no_spurious_frame", ok, 1'b0);

    // Reply with fresh capture, check two-cycle trigger latency
    target_mac = MAC1;
    target_ip = 32'hC0A8_0101;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    pulse_reply();
    wait_frame(20, ok, w);
    chk("reply_start", ok, 1'b1);
    chk("reply_latency", w, 1);
    frame_check("reply", R1, MAC1, -1);

    // Request to 192.168.1.9
    pulse_req(32'hC0A8_0109);
    wait_frame(20, ok, w);
    chk("req_start", ok, 1'b1);
    frame_check("req", Q1, BC, -1);

    // Simultaneous triggers: reply, gap, request, nothing more
    target_ip_req = 32'hC0A8_0107;
    arp_active = 1'b1;
    trig_reply = 1'b1;
    tick();
    arp_active = 1'b0;
    trig_reply = 1'b0;
    wait_frame(20, ok, w);
    chk("both_first_start", ok, 1'b1);
    frame_check("both_reply", R1, MAC1, -1);
    wait_frame(20, ok, w);
    chk("both_second_start", ok, 1'b1);
    chk("both_gap", w, 2);
    frame_check("both_req", Q3, BC, -1);
    wait_frame(60, ok, w);
    chk("both_no_third", ok, 1'b0);

    // Ready held low for 10 cycles
    mif.i_mac_ready = 1'b0;
    pulse_reply();
    seen = 1'b0;
    repeat (10) begin
      if (mif.o_mac_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("stall_no_output", seen, 1'b0);
    mif.i_mac_ready = 1'b1;
    wait_frame(20, ok, w);
    chk("stall_start", ok, 1'b1);
    chk("stall_latency", w, 1);
    frame_check("stall_reply", R1, MAC1, -1);

    // New capture plus reply trigger mid-frame
    pulse_reply();
    wait_frame(20, ok, w);
    chk("mid_start", ok, 1'b1);
    frame_check("mid_old", R1, MAC1, 5);
    wait_frame(20, ok, w);
    chk("mid_second_start", ok, 1'b1);
    chk("mid_gap", w, 2);
    frame_check("mid_new", R5, MAC2, -1);

    // Local IP update shows up as SPA
    source_ip = 32'h0A00_0005;
    s_ip_valid = 1'b1;
    tick();
    s_ip_valid = 1'b0;
    pulse_req(32'hC0A8_0109);
    wait_frame(20, ok, w);
    chk("spa_start", ok, 1'b1);
    frame_check("spa_req", Q6, BC, -1);

    // Reset at byte 12 with a reply pending
    pulse_req(32'hC0A8_0109);
    wait_frame(20, ok, w);
    chk("rst_start", ok, 1'b1);
    collect(12, 3, v, n, lp, lc, pz, d, dok, ab);
    chk("rst_aborted", ab, 1'b1);
    wait_frame(60, ok, w);
    chk("rst_no_output", ok, 1'b0);
    pulse_req(32'hC0A8_0109);
    wait_frame(20, ok, w);
    chk("rst_req_start", ok, 1'b1);
    frame_check("rst_req", Q1, BC, -1);
    pulse_reply();
    wait_frame(20, ok, w);
    chk("rst_reply_start", ok, 1'b1);
    frame_check("rst_reply", R7, 48'h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
